// File: rtl/vga_timing_gen_if.sv
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Raster timing bundle (counts, syncs, blanking, frame tick).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_timing_gen_if;
  logic [11:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic        frame_tick;

  modport master (
    output hcount, hsync, hblnk, vcount, vsync, vblnk, frame_tick
  );

  modport slave (
    input hcount, hsync, hblnk, vcount, vsync, vblnk, frame_tick
  );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : Raster h/v counter with registered sync, blank and frame tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int   H_VISIBLE = 800,
  parameter int   H_FP      = 40,
  parameter int   H_SYNC    = 128,
  parameter int   H_BP      = 88,
  parameter int   V_VISIBLE = 600,
  parameter int   V_FP      = 1,
  parameter int   V_SYNC    = 4,
  parameter int   V_BP      = 23,
  parameter logic SYNC_POL  = 1'b1
) (
  input  wire                     pclk,
  input  wire                     reset,
  vga_timing_gen_if.master        o_vga
);

  localparam logic [11:0] c_h_last       = 12'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] c_v_last       = 12'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] c_h_visible    = 12'(H_VISIBLE);
  localparam logic [11:0] c_v_visible    = 12'(V_VISIBLE);
  localparam logic [11:0] c_h_sync_start = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] c_h_sync_end   = 12'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [11:0] c_v_sync_start = 12'(V_VISIBLE + V_FP);
  localparam logic [11:0] c_v_sync_end   = 12'(V_VISIBLE + V_FP + V_SYNC);

  logic [11:0] r_hcount;
  logic [11:0] r_vcount;
  logic        r_hsync;
  logic        r_hblnk;
  logic        r_vsync;
  logic        r_vblnk;
  logic        r_frame_tick;

  logic [11:0] w_hcount_nxt;
  logic [11:0] w_vcount_nxt;
  logic        w_h_end;
  logic        w_v_end;

  always_comb begin
    w_h_end      = (r_hcount == c_h_last);
    w_v_end      = (r_vcount == c_v_last);
    w_hcount_nxt = w_h_end ? 12'd0 : r_hcount + 12'd1;
    w_vcount_nxt = r_vcount;
    if (w_h_end) begin
      w_vcount_nxt = w_v_end ? 12'd0 : r_vcount + 12'd1;
    end
  end

  // Flags are decoded from the next counter values so they land in the same
  // cycle as the counts they describe.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_hcount     <= 12'd0;
      r_vcount     <= 12'd0;
      r_hsync      <= ~SYNC_POL;
      r_hblnk      <= 1'b0;
      r_vsync      <= ~SYNC_POL;
      r_vblnk      <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_hcount     <= w_hcount_nxt;
      r_vcount     <= w_vcount_nxt;
      r_hblnk      <= (w_hcount_nxt >= c_h_visible);
      r_vblnk      <= (w_vcount_nxt >= c_v_visible);
      r_hsync      <= ((w_hcount_nxt >= c_h_sync_start) && (w_hcount_nxt < c_h_sync_end))
                      ? SYNC_POL : ~SYNC_POL;
      r_vsync      <= ((w_vcount_nxt >= c_v_sync_start) && (w_vcount_nxt < c_v_sync_end))
                      ? SYNC_POL : ~SYNC_POL;
      r_frame_tick <= (w_hcount_nxt == 12'd0) && (w_vcount_nxt == c_v_visible);
    end
  end

  assign o_vga.hcount     = r_hcount;
  assign o_vga.vcount     = r_vcount;
  assign o_vga.hsync      = r_hsync;
  assign o_vga.hblnk      = r_hblnk;
  assign o_vga.vsync      = r_vsync;
  assign o_vga.vblnk      = r_vblnk;
  assign o_vga.frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen on a reduced geometry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  localparam int HV  = 16;
  localparam int HFP = 2;
  localparam int HS  = 4;
  localparam int HB  = 3;
  localparam int HT  = HV + HFP + HS + HB;   // 25
  localparam int VV  = 10;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int VT  = VV + VFP + VS + VB;   // 16
  localparam int FT  = HT * VT;              // 400

  logic pclk = 1'b0;
  logic rst  = 1'b1;

  always #5 pclk = ~pclk;

  vga_timing_gen_if vga_a ();
  vga_timing_gen_if vga_b ();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
  ) u_dut_pos (
    .pclk  (pclk),
    .reset (rst),
    .o_vga (vga_a.master)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) u_dut_neg (
    .pclk  (pclk),
    .reset (rst),
    .o_vga (vga_b.master)
  );

  int checks = 0;
  int errors = 0;
  int n      = 0;   // linear raster position of the reference model

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic in_win(input int x, input int lo, input int len);
    return (x >= lo) && (x < lo + len);
  endfunction

  task automatic check_model();
    int h, v;
    h = n % HT;
    v = n / HT;
    chk("model_hcount", 32'(vga_a.hcount), 32'(h));
    chk("model_vcount", 32'(vga_a.vcount), 32'(v));
    chk("model_hblnk",  32'(vga_a.hblnk), 32'(h >= HV));
    chk("model_vblnk",  32'(vga_a.vblnk), 32'(v >= VV));
    chk("model_hsync",  32'(vga_a.hsync), 32'(in_win(h, HV + HFP, HS)));
    chk("model_vsync",  32'(vga_a.vsync), 32'(in_win(v, VV + VFP, VS)));
    chk("model_tick",   32'(vga_a.frame_tick), 32'(h == 0 && v == VV));
    chk("model_neg_hsync", 32'(vga_b.hsync), 32'(!in_win(h, HV + HFP, HS)));
    chk("model_neg_vsync", 32'(vga_b.vsync), 32'(!in_win(v, VV + VFP, VS)));
    chk("model_neg_hcount", 32'(vga_b.hcount), 32'(h));
  endtask

  task automatic step(input logic r);
    rst = r;
    @(posedge pclk);
    #1;
    n = r ? 0 : (n + 1) % FT;
    check_model();
  endtask

  typedef struct {
    logic rst;
    int   h;
    int   v;
    logic hs;
    logic hb;
    logic vs;
    logic vb;
    logic tk;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cnt_a, cnt_b, cnt_c, first_hs, tick_h, tick_v;
    logic done;

    vecs[0] = '{1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 7; i++) begin
      step(vecs[i].rst);
      chk("vec_hcount", 32'(vga_a.hcount), 32'(vecs[i].h));
      chk("vec_vcount", 32'(vga_a.vcount), 32'(vecs[i].v));
      chk("vec_hsync",  32'(vga_a.hsync), 32'(vecs[i].hs));
      chk("vec_hblnk",  32'(vga_a.hblnk), 32'(vecs[i].hb));
      chk("vec_vsync",  32'(vga_a.vsync), 32'(vecs[i].vs));
      chk("vec_vblnk",  32'(vga_a.vblnk), 32'(vecs[i].vb));
      chk("vec_tick",   32'(vga_a.frame_tick), 32'(vecs[i].tk));
      chk("vec_neg_hsync", 32'(vga_b.hsync), 32'(!vecs[i].hs));
    end

    // Line wrap.
    while (n != HT - 1) step(1'b0);
    chk("pre_wrap_hcount", 32'(vga_a.hcount), 32'(24));
    chk("pre_wrap_hblnk",  32'(vga_a.hblnk), 32'(1));
    step(1'b0);
    chk("line_wrap_hcount", 32'(vga_a.hcount), 32'(0));
    chk("line_wrap_vcount", 32'(vga_a.vcount), 32'(1));
    chk("line_wrap_hblnk",  32'(vga_a.hblnk), 32'(0));

    // One full line: blanking and sync widths.
    cnt_a = 0; cnt_b = 0; cnt_c = 0; first_hs = -1;
    for (int i = 0; i < HT; i++) begin
      if (vga_a.hblnk) cnt_a++;
      if (vga_a.hsync) begin
        cnt_b++;
        if (first_hs < 0) first_hs = int'(vga_a.hcount);
      end
      if (!vga_b.hsync) cnt_c++;
      step(1'b0);
    end
    chk("line_hblnk_cycles", 32'(cnt_a), 32'(9));
    chk("line_hsync_cycles", 32'(cnt_b), 32'(4));
    chk("line_hsync_start",  32'(first_hs), 32'(18));
    chk("line_neg_hsync_cycles", 32'(cnt_c), 32'(4));

    // One full frame from (0,2).
    cnt_a = 0; cnt_b = 0; cnt_c = 0; tick_h = -1; tick_v = -1;
    for (int i = 0; i < FT; i++) begin
      if (vga_a.vblnk) cnt_a++;
      if (vga_a.vsync) cnt_b++;
      if (vga_a.frame_tick) begin
        cnt_c++;
        tick_h = int'(vga_a.hcount);
        tick_v = int'(vga_a.vcount);
      end
      step(1'b0);
    end
    chk("frame_vblnk_cycles", 32'(cnt_a), 32'(6 * HT));
    chk("frame_vsync_cycles", 32'(cnt_b), 32'(2 * HT));
    chk("frame_tick_count",   32'(cnt_c), 32'(1));
    chk("frame_tick_h",       32'(tick_h), 32'(0));
    chk("frame_tick_v",       32'(tick_v), 32'(10));
    chk("frame_return_h",     32'(vga_a.hcount), 32'(0));
    chk("frame_return_v",     32'(vga_a.vcount), 32'(2));

    // Frame wrap at the last pixel.
    while (n != FT - 1) step(1'b0);
    chk("last_px_vblnk", 32'(vga_a.vblnk), 32'(1));
    step(1'b0);
    chk("fwrap_hcount", 32'(vga_a.hcount), 32'(0));
    chk("fwrap_vcount", 32'(vga_a.vcount), 32'(0));
    chk("fwrap_vblnk",  32'(vga_a.vblnk), 32'(0));
    chk("fwrap_vsync",  32'(vga_a.vsync), 32'(0));
    chk("fwrap_hblnk",  32'(vga_a.hblnk), 32'(0));

    // Mid-frame reset at (12,6), then time to the next frame tick.
    while (n != 6 * HT + 12) step(1'b0);
    step(1'b1);
    chk("midrst_hcount", 32'(vga_a.hcount), 32'(0));
    chk("midrst_vcount", 32'(vga_a.vcount), 32'(0));
    chk("midrst_tick",   32'(vga_a.frame_tick), 32'(0));
    cnt_a = 0;
    done  = 1'b0;
    while (!done && cnt_a < 1000) begin
      step(1'b0);
      cnt_a++;
      if (vga_a.frame_tick) done = 1'b1;
    end
    chk("midrst_tick_seen",  32'(done), 32'(1));
    chk("midrst_tick_delay", 32'(cnt_a), 32'(VV * HT));

    // Random resets against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing source for the video pipeline. It produces the horizontal and vertical count, sync and blanking stream that every downstream draw stage consumes and forwards: background, sprite and overlay stages. It also emits a once-per-frame tick that sprite position and rotation logic uses to update safely during vertical blanking. Default geometry is 800x600 @ 60 Hz with a 40 MHz pclk and positive sync polarity.

## Interface
Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_VISIBLE, 600, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1'b1, sync active level (1 = active-high)

Ports:
- pclk  input  1  pixel clock; all logic on its rising edge
- reset  input  1  reset, synchronous, active-high
- hcount  output  12  horizontal position, 0..H_TOTAL-1
- hsync  output  1  horizontal sync, level SYNC_POL while active
- hblnk  output  1  horizontal blanking, high when hcount >= H_VISIBLE
- vcount  output  12  vertical position, 0..V_TOTAL-1
- vsync  output  1  vertical sync, level SYNC_POL while active
- vblnk  output  1  vertical blanking, high when vcount >= V_VISIBLE
- frame_tick  output  1  one-cycle pulse at (hcount=0, vcount=V_VISIBLE)

## Operation
- Derived constants:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP, which is 1056 by default.
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP, which is 628 by default.
  - Sync windows are [VISIBLE+FP, VISIBLE+FP+SYNC), i.e. hsync on 840..967 and vsync on 601..604.
- Counters:
  - hcount increments every cycle.
  - At H_TOTAL-1, hcount wraps to 0 and vcount advances.
  - vcount wraps from V_TOTAL-1 to 0 when hcount also wraps.
  - No other transitions.
- All outputs are registers; there are no combinational paths to outputs.
  - Each flag is decoded from the next-state counter values and registered alongside the counters.
  - In any cycle, hsync, hblnk, vsync, vblnk and frame_tick correspond exactly to the hcount/vcount presented in that same cycle.
- Blanking/sync levels:
  - hblnk = (hcount >= H_VISIBLE).
  - vblnk = (vcount >= V_VISIBLE); vblnk stays asserted for whole lines, including hcount 0..H_VISIBLE-1 of blank lines.
  - hsync = SYNC_POL inside its window, else ~SYNC_POL; vsync likewise on vcount only.
- frame_tick is asserted for exactly one cycle per frame, the cycle where hcount=0 and vcount=V_VISIBLE. Downstream position registers update on it.
- Widths: counters are 12-bit unsigned and compares are unsigned. Parameters must satisfy H_TOTAL <= 4096 and V_TOTAL <= 4096; this is not checked in RTL.

## Timing
- Reset values (the cycle after reset is sampled high):
  - hcount=0, vcount=0
  - hblnk=0, vblnk=0, frame_tick=0
  - hsync=~SYNC_POL, vsync=~SYNC_POL
- These are exactly the decoded values for position (0,0), so the first post-reset cycle is a valid first pixel.
- Reset mid-frame: takes effect on the next edge regardless of position and returns to (0,0) as above. No partial-frame flush and no frame_tick is emitted.
- Reset held: outputs stay at reset values. The first edge with reset low advances to hcount=1.
- Latency: counter-to-flag alignment is zero cycles because both are registered together. Line period is H_TOTAL cycles; frame period is H_TOTAL*V_TOTAL cycles (663168 default).
- Simultaneous events: at (H_TOTAL-1, V_TOTAL-1) both counters wrap on the same edge to (0,0). All flags deassert except as decoded for (0,0).
- Downstream stages add their own pipeline delay. This block does not compensate for it.

## Test plan
- Reset with defaults: hold reset 3 cycles, then release -> during reset hcount=0, vcount=0, all flags 0 (SYNC_POL=1). The first cycle after release shows hcount=1.
- Line wrap: run to hcount=1055, vcount=0 -> the next cycle shows hcount=0, vcount=1. hblnk high on 800..1055 and low on 0..799.
- hsync window: over one line -> hsync is high on exactly hcount 840..967 (128 cycles). Repeat with SYNC_POL=0 -> inverted.
- Frame: run 663168 cycles from (0,0):
  - Counters return to (0,0).
  - vblnk high on lines 600..627.
  - vsync high on lines 601..604 (4*1056 = 4224 cycles).
  - frame_tick seen once, at (0,600).
- Frame wrap: at (1055,627) -> the next cycle is (0,0) with vblnk=0, vsync=0, hblnk=0.
- Mid-frame reset: assert reset at (512,300) for 1 cycle -> the next cycle shows (0,0) with reset values. The next frame_tick arrives 600*1056 = 633600 cycles after release.
